// File: rtl/note_seq_pkg.sv
// note_seq_pkg
// Shared definitions for the note sequencer and its score RAM.
//   - seqStateT   : sequencer states (IDLE, LOAD, PLAY, GAP, PAUSE)
//   - NOTE_SILENT : divider value that the tone generator plays as silence
//   - NOTE_W/DUR_W/ENTRY_W : layout of one score entry {note_div[21:0], dur[5:0]}
package note_seq_pkg;

   localparam int NOTE_W  = 22;
   localparam int DUR_W   = 6;
   localparam int ENTRY_W = NOTE_W + DUR_W;

   localparam logic [NOTE_W-1:0] NOTE_SILENT = 22'd1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      PLAY  = 3'd2,
      GAP   = 3'd3,
      PAUSE = 3'd4
   } seqStateT;

endpackage

// File: rtl/note_seq_score_ram.sv
// note_seq_score_ram
// DEPTH x ENTRY_W score storage for the note sequencer.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset (zeroes every entry)
//   wrEn/wrAddr/wrData : synchronous write port
//   rdAddr        : read address, sampled on every rising edge
//   rdData        : registered read data (returns old data on a same-address write)
module note_seq_score_ram
   import note_seq_pkg::*;
#(
   parameter int DEPTH = 32,
   localparam int AW = $clog2(DEPTH)
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               wrEn,
   input  logic [AW-1:0]      wrAddr,
   input  logic [ENTRY_W-1:0] wrData,
   input  logic [AW-1:0]      rdAddr,
   output logic [ENTRY_W-1:0] rdData
);

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [ENTRY_W-1:0] rdDataQ;

   // Storage and read register share one process. Because both the write and
   // the read use non-blocking updates, a read of the address being written in
   // the same cycle sees the previous contents. Reset empties the whole score
   // so a fresh board never plays garbage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         rdDataQ <= '0;
      end else begin
         if (wrEn) begin
            mem[wrAddr] <= wrData;
         end
         rdDataQ <= mem[rdAddr];
      end
   end

   assign rdData = rdDataQ;

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer
// Tempo-driven melody sequencer feeding note_div of the tone generator.
// Steps through a score of {note_div, dur} entries, holding each note for
// dur*BEAT_DIV cycles followed by GAP_CYCLES of silence (note_div == 1).
// Ports:
//   clk, rst           : clock, asynchronous active-low reset
//   loop               : (only with NOTE_SEQ_LOOP_EN) restart at entry 0 at end of score
//   start, stop, pause : playback control, priority stop > start > pause
//   wr_en/wr_addr/wr_data : score write port, accepted in every state
//   note_div           : registered divider output
//   busy               : high whenever not idle
//   done               : one-cycle pulse at natural end of score
//   idx                : index of the entry currently loaded
// Optional feature macro: NOTE_SEQ_LOOP_EN
module note_sequencer
   import note_seq_pkg::*;
#(
   parameter int BEAT_DIV   = 25_000_000,
   parameter int GAP_CYCLES = 1_000_000,
   parameter int DEPTH      = 32,
   localparam int AW = $clog2(DEPTH)
)(
   input  logic               clk,
   input  logic               rst,
`ifdef NOTE_SEQ_LOOP_EN
   input  logic               loop,
`endif
   input  logic               start,
   input  logic               stop,
   input  logic               pause,
   input  logic               wr_en,
   input  logic [AW-1:0]      wr_addr,
   input  logic [ENTRY_W-1:0] wr_data,
   output logic [NOTE_W-1:0]  note_div,
   output logic               busy,
   output logic               done,
   output logic [AW-1:0]      idx
);

   localparam int BEAT_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
   localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_DIV - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [AW-1:0]     IDX_LAST  = AW'(DEPTH - 1);

   seqStateT           stateQ, stateD;
   seqStateT           resumeQ, resumeD;
   logic [AW-1:0]      idxQ, idxD;
   logic [BEAT_W-1:0]  beatCntQ, beatCntD;
   logic [GAP_W-1:0]   gapCntQ, gapCntD;
   logic [DUR_W-1:0]   beatsLeftQ, beatsLeftD;
   logic [NOTE_W-1:0]  curNoteQ, curNoteD;
   logic [NOTE_W-1:0]  noteDivQ, noteDivD;
   logic               doneQ, doneD;
   logic               wrapEndQ, wrapEndD;
   logic               noteEnded;
   logic               loopEn;
   logic [ENTRY_W-1:0] rdData;
   logic [NOTE_W-1:0]  rdNote;
   logic [DUR_W-1:0]   rdDur;

`ifdef NOTE_SEQ_LOOP_EN
   assign loopEn = loop;
`else
   assign loopEn = 1'b0;
`endif

   // The RAM read address follows the next index, so the entry is already
   // sitting in the read register during the single LOAD cycle.
   note_seq_score_ram #(
      .DEPTH(DEPTH)
   ) u_score_ram (
      .clk   (clk),
      .rst   (rst),
      .wrEn  (wr_en),
      .wrAddr(wr_addr),
      .wrData(wr_data),
      .rdAddr(idxD),
      .rdData(rdData)
   );

   assign rdNote = rdData[ENTRY_W-1:DUR_W];
   assign rdDur  = rdData[DUR_W-1:0];

   // Next-state logic. The state case handles natural progress through the
   // score; afterwards the pause, start and stop overrides are layered on in
   // increasing priority. wrapEnd remembers that the entry just finished was
   // the last slot of the RAM, so the following LOAD behaves as if it had read
   // an end marker. The output divider is derived from the next state so it
   // changes on the same edge as the state, silencing everything except PLAY.
   always_comb begin
      stateD     = stateQ;
      resumeD    = resumeQ;
      idxD       = idxQ;
      beatCntD   = beatCntQ;
      gapCntD    = gapCntQ;
      beatsLeftD = beatsLeftQ;
      curNoteD   = curNoteQ;
      wrapEndD   = wrapEndQ;
      doneD      = 1'b0;
      noteEnded  = 1'b0;

      case (stateQ)
         LOAD: begin
            if (wrapEndQ || rdDur == '0) begin
               wrapEndD = 1'b0;
               if (loopEn && (wrapEndQ || idxQ != '0)) begin
                  stateD = LOAD;
                  idxD   = '0;
               end else begin
                  stateD = IDLE;
                  doneD  = 1'b1;
               end
            end else begin
               curNoteD   = rdNote;
               beatsLeftD = rdDur;
               beatCntD   = '0;
               stateD     = PLAY;
            end
         end
         PLAY: begin
            if (beatCntQ == BEAT_LAST) begin
               beatCntD   = '0;
               beatsLeftD = beatsLeftQ - DUR_W'(1);
               if (beatsLeftQ == DUR_W'(1)) begin
                  if (GAP_CYCLES == 0) begin
                     noteEnded = 1'b1;
                  end else begin
                     stateD  = GAP;
                     gapCntD = '0;
                  end
               end
            end else begin
               beatCntD = beatCntQ + BEAT_W'(1);
            end
         end
         GAP: begin
            if (gapCntQ == GAP_LAST) begin
               noteEnded = 1'b1;
            end else begin
               gapCntD = gapCntQ + GAP_W'(1);
            end
         end
         PAUSE: begin
            if (!pause) begin
               stateD = resumeQ;
            end
         end
         default: begin
            stateD = stateQ;
         end
      endcase

      if (noteEnded) begin
         stateD   = LOAD;
         idxD     = idxQ + AW'(1);
         wrapEndD = (idxQ == IDX_LAST);
      end

      if (pause && (stateQ == PLAY || stateQ == GAP) &&
          (stateD == PLAY || stateD == GAP)) begin
         resumeD = stateD;
         stateD  = PAUSE;
      end

      if (stop) begin
         stateD   = IDLE;
         wrapEndD = 1'b0;
         doneD    = 1'b0;
      end else if (start) begin
         stateD   = LOAD;
         idxD     = '0;
         wrapEndD = 1'b0;
         doneD    = 1'b0;
      end

      noteDivD = (stateD == PLAY) ? curNoteD : NOTE_SILENT;
   end

   // All sequencer state and the output register. Reset is asynchronous so a
   // reset in the middle of a note silences the speaker without waiting for
   // a clock edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stateQ     <= IDLE;
         resumeQ    <= IDLE;
         idxQ       <= '0;
         beatCntQ   <= '0;
         gapCntQ    <= '0;
         beatsLeftQ <= '0;
         curNoteQ   <= NOTE_SILENT;
         noteDivQ   <= NOTE_SILENT;
         doneQ      <= 1'b0;
         wrapEndQ   <= 1'b0;
      end else begin
         stateQ     <= stateD;
         resumeQ    <= resumeD;
         idxQ       <= idxD;
         beatCntQ   <= beatCntD;
         gapCntQ    <= gapCntD;
         beatsLeftQ <= beatsLeftD;
         curNoteQ   <= curNoteD;
         noteDivQ   <= noteDivD;
         doneQ      <= doneD;
         wrapEndQ   <= wrapEndD;
      end
   end

   assign note_div = noteDivQ;
   assign busy     = (stateQ != IDLE);
   assign done     = doneQ;
   assign idx      = idxQ;

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer
// Self-checking bench for note_sequencer with BEAT_DIV=4, GAP_CYCLES=2, DEPTH=8.
// Expected per-cycle traces of {note_div, busy, done, idx} are generated from
// the score contents by a timeline model; loop scenarios need NOTE_SEQ_LOOP_EN.
`timescale 1ns/1ps
module tb_note_sequencer;

   localparam int BEAT   = 4;
   localparam int GAPC   = 2;
   localparam int DEPTH  = 8;
   localparam int SILENT = 1;

   logic        clk;
   logic        rst;
`ifdef NOTE_SEQ_LOOP_EN
   logic        loop;
`endif
   logic        start;
   logic        stop;
   logic        pause;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [27:0] wr_data;
   logic [21:0] note_div;
   logic        busy;
   logic        done;
   logic [2:0]  idx;

   int          vectorCount;
   int          missCount;
   int          scoreNote [DEPTH];
   int          scoreDur  [DEPTH];
   logic [26:0] expQ [$];
   logic [26:0] got;

   note_sequencer #(
      .BEAT_DIV  (BEAT),
      .GAP_CYCLES(GAPC),
      .DEPTH     (DEPTH)
   ) dut (
      .clk     (clk),
      .rst     (rst),
`ifdef NOTE_SEQ_LOOP_EN
      .loop    (loop),
`endif
      .start   (start),
      .stop    (stop),
      .pause   (pause),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .note_div(note_div),
      .busy    (busy),
      .done    (done),
      .idx     (idx)
   );

   // Free-running 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Packs one expected observation {note, busy, done, idx}
   function automatic logic [26:0] pack(input int note, input logic b, input logic d, input int ix);
      logic [21:0] n;
      logic [2:0]  x;
      n = note[21:0];
      x = ix[2:0];
      return {n, b, d, x};
   endfunction

   // Timeline model: after start is sampled there is one LOAD cycle, then each
   // entry plays dur*BEAT cycles, GAPC silent cycles and the next LOAD cycle.
   // Reaching a marker (or running off the end of the RAM) yields a done cycle,
   // unless restarts remain and the marker is not entry 0, in which case a
   // fresh LOAD of entry 0 follows. A trailing idle cycle checks done is a pulse.
   task automatic buildExpected(input int restarts);
      int i;
      int r;
      expQ.delete();
      r = restarts;
      i = 0;
      expQ.push_back(pack(SILENT, 1'b1, 1'b0, 0));
      while (1) begin
         if (i == DEPTH || scoreDur[i] == 0) begin
            if (r > 0 && i != 0) begin
               r--;
               i = 0;
               expQ.push_back(pack(SILENT, 1'b1, 1'b0, 0));
               continue;
            end
            expQ.push_back(pack(SILENT, 1'b0, 1'b1, i % DEPTH));
            expQ.push_back(pack(SILENT, 1'b0, 1'b0, i % DEPTH));
            break;
         end
         for (int k = 0; k < scoreDur[i] * BEAT; k++) expQ.push_back(pack(scoreNote[i], 1'b1, 1'b0, i));
         for (int k = 0; k < GAPC; k++) expQ.push_back(pack(SILENT, 1'b1, 1'b0, i));
         i++;
         expQ.push_back(pack(SILENT, 1'b1, 1'b0, i % DEPTH));
      end
   endtask

   // Drives start/stop for one edge starting from a falling edge, returns at
   // the next falling edge (the first sample point after the edge)
   task automatic applyStimulus(input logic s, input logic st);
      start = s;
      stop  = st;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
   endtask

   // Writes one score entry while mirroring it into the bench's score copy
   task automatic writeEntry(input int addr, input int note, input int dur);
      wr_en   = 1'b1;
      wr_addr = addr[2:0];
      wr_data = {note[21:0], dur[5:0]};
      @(negedge clk);
      wr_en = 1'b0;
      scoreNote[addr] = note;
      scoreDur[addr]  = dur;
   endtask

   // Async reset mid-note, then an empty score must end two cycles after start
   task automatic test_reset();
      rst = 1'b1;
      #1 rst = 1'b0;
      #3;
      got = {note_div, busy, done, idx};
      vectorCount++;
      if (got !== pack(SILENT, 1'b0, 1'b0, 0)) begin
         missCount++;
         $display("[TB] FAIL reset_initial: got %h expected %h", got, pack(SILENT, 1'b0, 1'b0, 0));
      end
      @(negedge clk);
      rst = 1'b1;
      writeEntry(0, 500, 2);
      writeEntry(1, 0, 0);
      applyStimulus(1'b1, 1'b0);
      repeat (4) @(negedge clk);
      vectorCount++;
      if (note_div !== 22'd500) begin
         missCount++;
         $display("[TB] FAIL reset_preplay: note_div %0d expected 500", note_div);
      end
      #2 rst = 1'b0;
      #1;
      got = {note_div, busy, done, idx};
      vectorCount++;
      if (got !== pack(SILENT, 1'b0, 1'b0, 0)) begin
         missCount++;
         $display("[TB] FAIL reset_midnote: got %h expected %h", got, pack(SILENT, 1'b0, 1'b0, 0));
      end
      for (int a = 0; a < DEPTH; a++) begin
         scoreNote[a] = 0;
         scoreDur[a]  = 0;
      end
      @(negedge clk);
      rst = 1'b1;
      buildExpected(0);
      applyStimulus(1'b1, 1'b0);
      for (int c = 0; c < expQ.size(); c++) begin
         if (c > 0) @(negedge clk);
         got = {note_div, busy, done, idx};
         vectorCount++;
         if (got !== expQ[c]) begin
            missCount++;
            $display("[TB] FAIL reset_empty c=%0d: note=%0d busy=%b done=%b idx=%0d expected note=%0d busy=%b done=%b idx=%0d",
                     c, got[26:5], got[4], got[3], got[2:0], expQ[c][26:5], expQ[c][4], expQ[c][3], expQ[c][2:0]);
         end
      end
   endtask

   // Two-note score with an explicit end marker
   task automatic test_basic();
      writeEntry(0, 500, 2);
      writeEntry(1, 750, 1);
      writeEntry(2, 0, 0);
      buildExpected(0);
      applyStimulus(1'b1, 1'b0);
      for (int c = 0; c < expQ.size(); c++) begin
         if (c > 0) @(negedge clk);
         got = {note_div, busy, done, idx};
         vectorCount++;
         if (got !== expQ[c]) begin
            missCount++;
            $display("[TB] FAIL basic c=%0d: note=%0d busy=%b done=%b idx=%0d expected note=%0d busy=%b done=%b idx=%0d",
                     c, got[26:5], got[4], got[3], got[2:0], expQ[c][26:5], expQ[c][4], expQ[c][3], expQ[c][2:0]);
         end
      end
   endtask

   // Pause for 10 cycles after two cycles of note 0; the note resumes intact
   task automatic test_pause();
      buildExpected(0);
      for (int k = 0; k < 10; k++) expQ.insert(3, pack(SILENT, 1'b1, 1'b0, 0));
      applyStimulus(1'b1, 1'b0);
      for (int c = 0; c < expQ.size(); c++) begin
         if (c > 0) @(negedge clk);
         got = {note_div, busy, done, idx};
         vectorCount++;
         if (got !== expQ[c]) begin
            missCount++;
            $display("[TB] FAIL pause c=%0d: note=%0d busy=%b done=%b idx=%0d expected note=%0d busy=%b done=%b idx=%0d",
                     c, got[26:5], got[4], got[3], got[2:0], expQ[c][26:5], expQ[c][4], expQ[c][3], expQ[c][2:0]);
         end
         if (c == 2)  pause = 1'b1;
         if (c == 12) pause = 1'b0;
      end
   endtask

   // stop and start together mid-note must go idle without done; then replay
   task automatic test_stop_start();
      buildExpected(0);
      applyStimulus(1'b1, 1'b0);
      for (int c = 0; c < 5; c++) begin
         if (c > 0) @(negedge clk);
         got = {note_div, busy, done, idx};
         vectorCount++;
         if (got !== expQ[c]) begin
            missCount++;
            $display("[TB] FAIL stop_pre c=%0d: got %h expected %h", c, got, expQ[c]);
         end
      end
      applyStimulus(1'b1, 1'b1);
      for (int c = 0; c < 4; c++) begin
         if (c > 0) @(negedge clk);
         got = {note_div, busy, done, idx};
         vectorCount++;
         if (got !== pack(SILENT, 1'b0, 1'b0, 0)) begin
            missCount++;
            $display("[TB] FAIL stop_idle c=%0d: got %h expected %h", c, got, pack(SILENT, 1'b0, 1'b0, 0));
         end
      end
      applyStimulus(1'b1, 1'b0);
      for (int c = 0; c < expQ.size(); c++) begin
         if (c > 0) @(negedge clk);
         got = {note_div, busy, done, idx};
         vectorCount++;
         if (got !== expQ[c]) begin
            missCount++;
            $display("[TB] FAIL stop_replay c=%0d: got %h expected %h", c, got, expQ[c]);
         end
      end
   endtask

   // Writing the playing entry, and writing entry 1 on the very edge that
   // loads it, must both leave this pass unchanged; the next pass uses new data
   task automatic test_write_during_play();
      buildExpected(0);
      applyStimulus(1'b1, 1'b0);
      for (int c = 0; c < expQ.size(); c++) begin
         if (c > 0) @(negedge clk);
         got = {note_div, busy, done, idx};
         vectorCount++;
         if (got !== expQ[c]) begin
            missCount++;
            $display("[TB] FAIL write_play c=%0d: got %h expected %h", c, got, expQ[c]);
         end
         wr_en = 1'b0;
         if (c == 4) begin
            wr_en = 1'b1; wr_addr = 3'd0; wr_data = {22'd1234, 6'd1};
         end
         if (c == 10) begin
            wr_en = 1'b1; wr_addr = 3'd1; wr_data = {22'd4321, 6'd3};
         end
      end
      wr_en = 1'b0;
      scoreNote[0] = 1234; scoreDur[0] = 1;
      scoreNote[1] = 4321; scoreDur[1] = 3;
      buildExpected(0);
      applyStimulus(1'b1, 1'b0);
      for (int c = 0; c < expQ.size(); c++) begin
         if (c > 0) @(negedge clk);
         got = {note_div, busy, done, idx};
         vectorCount++;
         if (got !== expQ[c]) begin
            missCount++;
            $display("[TB] FAIL write_next c=%0d: got %h expected %h", c, got, expQ[c]);
         end
      end
   endtask

   // Every slot holds a note: idx runs 0..7, wraps to 0 and the score ends
   task automatic test_full_wrap();
      for (int a = 0; a < DEPTH; a++) writeEntry(a, 100, 1);
      buildExpected(0);
      applyStimulus(1'b1, 1'b0);
      for (int c = 0; c < expQ.size(); c++) begin
         if (c > 0) @(negedge clk);
         got = {note_div, busy, done, idx};
         vectorCount++;
         if (got !== expQ[c]) begin
            missCount++;
            $display("[TB] FAIL full_wrap c=%0d: got %h expected %h", c, got, expQ[c]);
         end
      end
   endtask

   // Random scores of random length (0 = empty, 8 = no marker at all)
   task automatic test_random_scores();
      int len;
      for (int it = 0; it < 6; it++) begin
         len = $urandom_range(DEPTH, 0);
         for (int a = 0; a < DEPTH; a++) begin
            if (a < len) writeEntry(a, $urandom_range(4194303, 2), $urandom_range(3, 1));
            else if (a == len) writeEntry(a, $urandom_range(4194303, 0), 0);
            else writeEntry(a, $urandom_range(4194303, 0), $urandom_range(3, 0));
         end
         buildExpected(0);
         applyStimulus(1'b1, 1'b0);
         for (int c = 0; c < expQ.size(); c++) begin
            if (c > 0) @(negedge clk);
            got = {note_div, busy, done, idx};
            vectorCount++;
            if (got !== expQ[c]) begin
               missCount++;
               $display("[TB] FAIL random it=%0d c=%0d: got %h expected %h", it, c, got, expQ[c]);
            end
         end
      end
   endtask

`ifdef NOTE_SEQ_LOOP_EN
   // Looping replays from entry 0 with no done; dropping loop ends at the next marker
   task automatic test_loop();
      writeEntry(0, 500, 2);
      writeEntry(1, 750, 1);
      writeEntry(2, 0, 0);
      loop = 1'b1;
      buildExpected(1);
      applyStimulus(1'b1, 1'b0);
      for (int c = 0; c < expQ.size(); c++) begin
         if (c > 0) @(negedge clk);
         got = {note_div, busy, done, idx};
         vectorCount++;
         if (got !== expQ[c]) begin
            missCount++;
            $display("[TB] FAIL loop c=%0d: got %h expected %h", c, got, expQ[c]);
         end
         if (c == 25) loop = 1'b0;
      end
   endtask
`endif

   // Hard bound on total run time
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vectorCount = 0;
      missCount   = 0;
      start   = 1'b0;
      stop    = 1'b0;
      pause   = 1'b0;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
`ifdef NOTE_SEQ_LOOP_EN
      loop    = 1'b0;
`endif
      for (int a = 0; a < DEPTH; a++) begin
         scoreNote[a] = 0;
         scoreDur[a]  = 0;
      end
      test_reset();
      test_basic();
      test_pause();
      test_stop_start();
      test_write_during_play();
      test_full_wrap();
      test_random_scores();
`ifdef NOTE_SEQ_LOOP_EN
      test_loop();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Tempo-driven melody sequencer that drives the `note_div` input of the tone generator in the DJ board audio path. It holds a small score RAM of (note divider, duration) entries, loaded through a write port. On command it steps through the score at a beat rate derived from the crystal clock, inserting a short silent articulation gap between notes. Silence is always presented as `note_div == 1`, which the tone generator maps to zero amplitude.

## Interface
Parameters:
- `BEAT_DIV`, default 25_000_000: clk cycles per beat; must be ≥ 1.
- `GAP_CYCLES`, default 1_000_000: silent cycles inserted after each note; 0 disables the gap.
- `DEPTH`, default 32: score entries; power of two.

Ports:
- `clk`  in  1  crystal clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  level-sampled pulse: begin playback at index 0.
- `stop`  in  1  pulse: abort playback, return to idle.
- `pause`  in  1  level: hold the current note position while high.
- `wr_en`  in  1  score write strobe.
- `wr_addr`  in  log2(DEPTH)  score write address.
- `wr_data`  in  28  `{note_div[21:0], dur[5:0]}`; `dur` is in beats; `dur == 0` is the end-of-score marker.
- `note_div`  out  22  registered divider to the tone generator.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse at natural end of score.
- `idx`  out  log2(DEPTH)  index of the entry currently loaded.

## Operation
- FSM states: IDLE, LOAD, PLAY, GAP, PAUSE.
- **IDLE**
  - `note_div = 1`.
  - `start` → LOAD with `idx = 0`.
- **LOAD** (1 cycle)
  - Registered read of `score[idx]`.
  - If `dur == 0`: end of score. Pulse `done` and go to IDLE (or restart at `idx = 0` when looping; see Configuration).
  - Otherwise latch `note_div` and `dur` into the output and the remaining-beat counter, clear the beat counter, and go to PLAY.
- **PLAY**
  - Beat counter counts 0..BEAT_DIV-1.
  - On wrap, decrement remaining beats.
  - When the last beat wraps: go to GAP (or straight to next LOAD if `GAP_CYCLES == 0`).
- **GAP**
  - `note_div = 1` for exactly GAP_CYCLES cycles, then LOAD with `idx + 1`.
- **Index wrap**: when `idx == DEPTH-1` completes, the score ends as if the next entry were a marker. `idx` wraps to 0.
- **PAUSE**
  - Entered from PLAY or GAP while `pause` is high.
  - Beat and gap counters freeze and `note_div` is forced to 1.
  - On `pause` low, return to the saved state with counters intact.
- **Priority**: `stop` > `start` > `pause`.
  - `stop` in any state → IDLE next cycle, `note_div = 1`, no `done` pulse.
  - `start` while busy restarts at index 0.
- **Writes** are accepted in every state.
  - A write to the entry currently playing does not alter the latched note; it takes effect on the next LOAD of that index.
  - A write and a LOAD read of the same address in the same cycle return the old data.
- **Reset**
  - Outputs: `note_div = 1`, `busy = 0`, `done = 0`, `idx = 0`.
  - State: FSM IDLE, all counters 0.
  - Score RAM: all entries 0 (empty score).
  - Reset asserted mid-note silences the output immediately, since `rst` is asynchronous.

## Timing
- Latency from `start` to the first `note_div` change: 2 cycles (start sampled, LOAD, output registered).
- Note-on time: exactly `dur × BEAT_DIV` cycles.
- Gap: exactly GAP_CYCLES cycles.
- LOAD adds 1 cycle per note, during which the previous value (the gap value 1) is held.
- `done` is asserted the cycle after a LOAD that reads a marker.
- Empty score: `start` → `done` 2 cycles later, with `note_div` remaining 1 throughout.
- `pause` takes effect the cycle after it is sampled high. Resume likewise.

## Configuration
- Macro `NOTE_SEQ_LOOP_EN`.
- **Defined**: an extra input port `loop` (1 bit).
  - At end of score with `loop` high: no `done` pulse; LOAD restarts at `idx = 0`.
  - If entry 0 is itself a marker: `done` pulses and the FSM goes to IDLE, so an empty score cannot loop forever.
- **Undefined**: no `loop` port; end of score always pulses `done` and goes to IDLE.

## Structure
- Shared package `note_seq_pkg`:
  - state enum
  - `NOTE_SILENT = 22'd1`
  - entry field widths (22/6)
  - `ENTRY_W = 28`
- One sub-module: `note_seq_score_ram`, a DEPTH×28 register file with a synchronous write, a registered read, and asynchronous zeroing reset.
- The FSM, counters and output register live in `note_sequencer`.

## Test plan
Bench uses BEAT_DIV=4, GAP_CYCLES=2, DEPTH=8.
1. **Reset**: assert `rst` low mid-PLAY → `note_div` = 1, `busy` = 0, `idx` = 0 within the same cycle. After release, `start` → `done` after 2 cycles (empty RAM).
2. **Basic score**: write entry 0 = {500, 2}, entry 1 = {750, 1}, entry 2 = {0, 0}, then `start`.
   - `note_div` = 500 for 8 cycles, then 1 for 2 cycles, then 1 for 1 LOAD cycle.
   - Then 750 for 4 cycles, then gap, then `done` pulse, `busy` low.
3. **Pause**: score as in test 2; hold `pause` high for 10 cycles at beat count 2 of note 0.
   - `note_div` = 1 while paused.
   - After release, 500 resumes for the remaining 6 cycles.
4. **Stop and start priority**: `stop` and `start` high in the same cycle mid-note → IDLE, no `done` pulse. A later lone `start` replays from `idx = 0`.
5. **Full wrap**: all 8 entries = {100, 1} → 8 notes, then `done`, with `idx` sequence 0..7 then 0.
6. **Loop** (`NOTE_SEQ_LOOP_EN`, `loop` = 1), score as in test 2 → notes 500, 750, 500, … with no `done` pulse. Clearing `loop` then produces `done` at the next marker.
